// File: rtl/prio_irq_if.sv
// Request/grant bundle for prio_irq_encoder: the producer drives requests and acks,
// and the encoder returns the registered grant and its status vectors.
interface prio_irq_if #(
  parameter int N = 8
) ();
  localparam int W = $clog2(N);

  logic [N-1:0] req;
  logic [N-1:0] mask;
  logic         ack;
  logic         ovr_clr;
  logic [W-1:0] code;
  logic         valid;
  logic [N-1:0] pending;
  logic [N-1:0] ovr;

  modport master (
    output req, mask, ack, ovr_clr,
    input  code, valid, pending, ovr
  );

  modport slave (
    input  req, mask, ack, ovr_clr,
    output code, valid, pending, ovr
  );
endinterface

// File: rtl/prio_irq_encoder.sv
// Registered interrupt priority encoder with pending/overrun tracking.
// Define PRIO_ENC_ROUND_ROBIN_EN for rotating priority; fixed highest-index priority otherwise.
module prio_irq_encoder #(
  parameter int N = 8
) (
  input  logic      clk,
  input  logic      rst,
  prio_irq_if.slave bus
);
  localparam int W = $clog2(N);

  logic [N-1:0] pending_q, pending_d;
  logic [N-1:0] ovr_q, ovr_d;
  logic [W-1:0] code_q, code_d;
  logic         valid_q, valid_d;
  logic [N-1:0] eligible;
  logic [N-1:0] grant_clr;
  logic [W-1:0] sel;
  logic         slot_free;

`ifdef PRIO_ENC_ROUND_ROBIN_EN
  logic [W-1:0] ptr_q, ptr_d;

  // Offset N wraps to the last grant itself, so it is checked last.
  function automatic logic [W-1:0] pick(input logic [N-1:0] elig, input logic [W-1:0] last);
    logic [W-1:0] idx;
    logic [W-1:0] res;
    res = '0;
    for (int j = N; j >= 1; j--) begin
      idx = last - W'(j);
      if (elig[idx]) res = idx;
    end
    return res;
  endfunction

  assign sel = pick(eligible, ptr_q);
`else
  function automatic logic [W-1:0] pick(input logic [N-1:0] elig);
    logic [W-1:0] res;
    res = '0;
    for (int i = 0; i < N; i++) begin
      if (elig[i]) res = W'(i);
    end
    return res;
  endfunction

  assign sel = pick(eligible);
`endif

  always_comb begin
    eligible  = pending_q & ~bus.mask;
    slot_free = ~valid_q | bus.ack;
    grant_clr = '0;
    code_d    = code_q;
    valid_d   = valid_q;
`ifdef PRIO_ENC_ROUND_ROBIN_EN
    ptr_d     = ptr_q;
`endif
    if (slot_free) begin
      valid_d = |eligible;
      if (|eligible) begin
        code_d    = sel;
        grant_clr = N'(1) << sel;
`ifdef PRIO_ENC_ROUND_ROBIN_EN
        ptr_d     = sel;
`endif
      end
    end
    // A request landing on a bit being granted re-arms it rather than overrunning.
    pending_d = (pending_q & ~grant_clr) | bus.req;
    ovr_d     = (ovr_q & ~{N{bus.ovr_clr}}) | (bus.req & pending_q & ~grant_clr);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending_q <= '0;
      ovr_q     <= '0;
      code_q    <= '0;
      valid_q   <= 1'b0;
`ifdef PRIO_ENC_ROUND_ROBIN_EN
      ptr_q     <= W'(N - 1);
`endif
    end else begin
      pending_q <= pending_d;
      ovr_q     <= ovr_d;
      code_q    <= code_d;
      valid_q   <= valid_d;
`ifdef PRIO_ENC_ROUND_ROBIN_EN
      ptr_q     <= ptr_d;
`endif
    end
  end

  assign bus.code    = code_q;
  assign bus.valid   = valid_q;
  assign bus.pending = pending_q;
  assign bus.ovr     = ovr_q;
endmodule

// File: tb/tb_prio_irq_encoder.sv
// Directed table-driven bench for prio_irq_encoder (N=8), with hand-written
// sequences for overrun, asynchronous reset and long masked hold.
module tb_prio_irq_encoder;
  logic clk;
  logic rst;
  int   checks;
  int   errors;

  prio_irq_if #(.N(8)) bus ();

  prio_irq_encoder #(.N(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       pre_rst;
    logic [7:0] req;
    logic [7:0] mask;
    logic       ack;
    logic       ovr_clr;
    logic [2:0] code;
    logic       valid;
    logic [7:0] pending;
    logic [7:0] ovr;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input logic pr, input logic [7:0] rq, input logic [7:0] mk_,
                              input logic ak, input logic oc, input logic [2:0] cd,
                              input logic vd, input logic [7:0] pd, input logic [7:0] ov);
    vec_t v;
    v.pre_rst = pr; v.req = rq; v.mask = mk_; v.ack = ak; v.ovr_clr = oc;
    v.code = cd; v.valid = vd; v.pending = pd; v.ovr = ov;
    return v;
  endfunction

  task automatic check(input string name, input logic [2:0] cd, input logic vd,
                       input logic [7:0] pd, input logic [7:0] ov);
    checks++;
    if (bus.code !== cd || bus.valid !== vd || bus.pending !== pd || bus.ovr !== ov) begin
      errors++;
      $display("FAIL %s: got code=%0d valid=%b pending=%h ovr=%h, want code=%0d valid=%b pending=%h ovr=%h",
               name, bus.code, bus.valid, bus.pending, bus.ovr, cd, vd, pd, ov);
    end
  endtask

  task automatic drive(input logic [7:0] rq, input logic [7:0] mk_, input logic ak, input logic oc);
    @(negedge clk);
    bus.req = rq; bus.mask = mk_; bus.ack = ak; bus.ovr_clr = oc;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    bus.req = '0; bus.mask = '0; bus.ack = 1'b0; bus.ovr_clr = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    logic [7:0] pend;
    logic [2:0] c;
    checks = 0;
    errors = 0;
    rst = 1'b1;
    bus.req = '0; bus.mask = '0; bus.ack = 1'b0; bus.ovr_clr = 1'b0;
    #12;
    check("reset_state", 3'd0, 1'b0, 8'h00, 8'h00);

    // Two requests, ack held: highest first, then the lower, then idle.
    tbl.push_back(mk(1, 8'h12, 8'h00, 1, 0, 3'd0, 0, 8'h12, 8'h00));
    tbl.push_back(mk(0, 8'h00, 8'h00, 1, 0, 3'd4, 1, 8'h02, 8'h00));
    tbl.push_back(mk(0, 8'h00, 8'h00, 1, 0, 3'd1, 1, 8'h00, 8'h00));
    tbl.push_back(mk(0, 8'h00, 8'h00, 1, 0, 3'd1, 0, 8'h00, 8'h00));
    // Masked channel retained, granted after the mask clears.
    tbl.push_back(mk(1, 8'h81, 8'h80, 1, 0, 3'd0, 0, 8'h81, 8'h00));
    tbl.push_back(mk(0, 8'h00, 8'h80, 1, 0, 3'd0, 1, 8'h80, 8'h00));
    tbl.push_back(mk(0, 8'h00, 8'h00, 1, 0, 3'd7, 1, 8'h00, 8'h00));
    tbl.push_back(mk(0, 8'h00, 8'h00, 1, 0, 3'd7, 0, 8'h00, 8'h00));
    // Held grant, overrun, ovr_clr priority, mask not revoking, set-over-clear.
    tbl.push_back(mk(1, 8'h20, 8'h00, 0, 0, 3'd0, 0, 8'h20, 8'h00));
    tbl.push_back(mk(0, 8'h00, 8'h00, 0, 0, 3'd5, 1, 8'h00, 8'h00));
    tbl.push_back(mk(0, 8'h20, 8'h00, 0, 0, 3'd5, 1, 8'h20, 8'h00));
    tbl.push_back(mk(0, 8'h20, 8'h00, 0, 0, 3'd5, 1, 8'h20, 8'h20));
    tbl.push_back(mk(0, 8'h20, 8'h00, 0, 1, 3'd5, 1, 8'h20, 8'h20));
    tbl.push_back(mk(0, 8'h00, 8'h00, 0, 1, 3'd5, 1, 8'h20, 8'h00));
    tbl.push_back(mk(0, 8'h00, 8'hFF, 0, 0, 3'd5, 1, 8'h20, 8'h00));
    tbl.push_back(mk(0, 8'h20, 8'h00, 1, 0, 3'd5, 1, 8'h20, 8'h00));
    tbl.push_back(mk(0, 8'h00, 8'h00, 1, 0, 3'd5, 1, 8'h00, 8'h00));
    tbl.push_back(mk(0, 8'h00, 8'h00, 1, 0, 3'd5, 0, 8'h00, 8'h00));
    tbl.push_back(mk(0, 8'h00, 8'h00, 1, 0, 3'd5, 0, 8'h00, 8'h00));
    // All channels at once, ack held: full sweep in policy order.
    tbl.push_back(mk(1, 8'hFF, 8'h00, 1, 0, 3'd0, 0, 8'hFF, 8'h00));
    pend = 8'hFF;
    for (int k = 0; k < 8; k++) begin
`ifdef PRIO_ENC_ROUND_ROBIN_EN
      c = (k == 7) ? 3'd7 : 3'(6 - k);
`else
      c = 3'(7 - k);
`endif
      pend[c] = 1'b0;
      tbl.push_back(mk(0, 8'h00, 8'h00, 1, 0, c, 1, pend, 8'h00));
    end
    tbl.push_back(mk(0, 8'h00, 8'h00, 1, 0, c, 0, 8'h00, 8'h00));

    foreach (tbl[i]) begin
      if (tbl[i].pre_rst) do_reset();
      drive(tbl[i].req, tbl[i].mask, tbl[i].ack, tbl[i].ovr_clr);
      check($sformatf("vec%0d", i), tbl[i].code, tbl[i].valid, tbl[i].pending, tbl[i].ovr);
    end

    // Asynchronous reset while a grant is presented with pending and overrun set.
    do_reset();
    drive(8'h04, 8'h00, 0, 0);
    drive(8'h0C, 8'h00, 0, 0);
    check("rst_setup_a", 3'd2, 1'b1, 8'h0C, 8'h00);
    drive(8'h0C, 8'h00, 0, 0);
    check("rst_setup_b", 3'd2, 1'b1, 8'h0C, 8'h0C);
    @(negedge clk);
    bus.ack = 1'b1; bus.req = 8'hFF;
    #1 rst = 1'b1;
    #1 check("rst_async", 3'd0, 1'b0, 8'h00, 8'h00);
    @(posedge clk);
    #1 check("rst_held", 3'd0, 1'b0, 8'h00, 8'h00);
    @(negedge clk);
    rst = 1'b0; bus.req = 8'h00; bus.ack = 1'b0;
    drive(8'h10, 8'h00, 0, 0);
    check("post_rst_sample", 3'd0, 1'b0, 8'h10, 8'h00);
    drive(8'h00, 8'h00, 0, 0);
    check("post_rst_grant", 3'd4, 1'b1, 8'h00, 8'h00);

    // Everything masked: requests retained, nothing granted.
    do_reset();
    drive(8'h3C, 8'hFF, 1, 0);
    check("mask_all_load", 3'd0, 1'b0, 8'h3C, 8'h00);
    for (int k = 0; k < 100; k++) begin
      drive(8'h00, 8'hFF, 1, 0);
      check($sformatf("mask_all_%0d", k), 3'd0, 1'b0, 8'h3C, 8'h00);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete, want completion");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/prio_irq_encoder.md
PRIO_IRQ_ENCODER -- requirements
Module: prio_irq_encoder

Interface
REQ-001 Parameter: N, 8, number of request channels; power of two, 2..64.
REQ-002 Derived constant: W = $clog2(N), width of the code output.
REQ-003 Port: clk  in  1  single clock; all state changes on its rising edge.
REQ-004 Port: rst  in  1  asynchronous, active-high reset.
REQ-005 Port: req  in  N  per-channel request, sampled each rising clk edge.
REQ-006 Port: mask  in  N  per-channel mask; 1 = channel ineligible for grant, request still recorded.
REQ-007 Port: ack  in  1  consumer accepts the presented code.
REQ-008 Port: ovr_clr  in  1  clears all overrun flags.
REQ-009 Port: code  out  W  index of the granted channel, registered.
REQ-010 Port: valid  out  1  code holds a grant not yet acknowledged.
REQ-011 Port: pending  out  N  recorded, not-yet-granted requests.
REQ-012 Port: ovr  out  N  sticky per-channel overrun flags.

Function
REQ-013 Each edge: pending[i] next = (pending[i] & ~grant_clr[i]) | req[i]; set wins over clear on the same bit.
REQ-014 Grant slot is free when valid=0, or when valid=1 and ack=1 at that edge.
REQ-015 On a free slot with eligible = pending & ~mask nonzero: load code with the selected index, set valid=1, assert grant_clr for that index.
REQ-016 On a free slot with eligible = 0: valid next = 0; code holds its previous value.
REQ-017 Selection (default): highest set index of eligible wins, i.e. the 8-input priority encoder generalised to N.
REQ-018 While valid=1 and ack=0: code and valid hold stable; no new grant is made.
REQ-019 Consecutive acks give one grant per cycle; no bubble is inserted between grants.
REQ-020 ack while valid=0 is ignored.
REQ-021 Latency: req[i] high at edge k sets pending[i]; the earliest valid with code=i is after edge k+1.
REQ-022 Overrun: ovr[i] sets when req[i]=1 at an edge while pending[i]=1 and grant_clr[i]=0.
REQ-023 ovr_clr=1 clears every ovr bit; a same-edge set wins over ovr_clr for that bit.
REQ-024 A masked pending bit is retained indefinitely and becomes grantable the cycle after mask[i] falls.
REQ-025 A mask change does not revoke a grant already presented on code/valid.

Reset
REQ-026 While rst=1, independent of clk: pending=0, ovr=0, valid=0, code=0, round-robin pointer=N-1.
REQ-027 A reset mid-grant discards the presented grant and all pending requests; ack arriving in the same cycle is ignored.
REQ-028 The first grant after rst falls follows REQ-021 from the first sampled req.

Configuration
REQ-029 Macro PRIO_ENC_ROUND_ROBIN_EN selects the arbitration policy.
REQ-030 Macro undefined: fixed priority per REQ-017.
REQ-031 Macro defined: rotating priority; search order starts at index (last_grant-1) mod N, descending with wrap; last_grant updates on every grant.
REQ-032 Macro defined: the round-robin pointer resets to N-1, so the first search starts at N-2.
REQ-033 Macro defined: with a single eligible channel, behaviour is identical to fixed priority.

Verification (N=8)
REQ-034 req=8'h12 for one cycle, ack held 1 -> code=4 valid=1, then code=1 valid=1, then valid=0, pending=0.
REQ-035 pending=8'h81, mask=8'h80, ack=1 -> code=0 granted, bit 7 held in pending; clear mask -> code=7 next grant.
REQ-036 valid=1 with code=5, ack=0, req[5] pulsed twice -> code stays 5, ovr[5]=1 after the second pulse; ovr_clr -> ovr=0.
REQ-037 req=8'hFF held one cycle, ack=1 continuously: fixed build -> codes 7,6,5..0; RR build -> codes 6,5..0,7.
REQ-038 rst pulse while valid=1 and pending=8'h0C -> immediately valid=0, code=0, pending=0, ovr=0.
REQ-039 All requests masked, req=8'h3C -> valid stays 0 and pending=8'h3C for 100 cycles.
